// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forwarding-select generator for the 5-stage pipeline.
// Tracks a shadow pipeline of register-usage records for E, M and W and derives
// the D-stage stall request plus every forwarding MUX select from them.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   d_valid_i                   D holds a real instruction (0 = bubble)
//   d_rs_i, d_rt_i              D source registers
//   d_tuse_rs_i, d_tuse_rt_i    cycles until operand consumed (3 = unused)
//   d_a3_i, d_tnew_i            D destination register and its Tnew at E entry
//   stall_o                     freeze PC and F/D, bubble into D/E (combinational)
//   fwd_d_rs_o, fwd_d_rt_o      D compare MUX3: 0 RF, 1 M result, 2 E result
//   fwd_e_rs_o, fwd_e_rt_o      ALU operand MUX3: 0 D/E reg, 1 W result, 2 M result
//   fwd_m_rt_o                  store-data MUX2: 0 E/M reg, 1 W result
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_valid_i,
  input  logic [4:0] d_rs_i,
  input  logic [4:0] d_rt_i,
  input  logic [1:0] d_tuse_rs_i,
  input  logic [1:0] d_tuse_rt_i,
  input  logic [4:0] d_a3_i,
  input  logic [1:0] d_tnew_i,
  output logic       stall_o,
  output logic [1:0] fwd_d_rs_o,
  output logic [1:0] fwd_d_rt_o,
  output logic [1:0] fwd_e_rs_o,
  output logic [1:0] fwd_e_rt_o,
  output logic       fwd_m_rt_o
);

  localparam int unsigned RegW = 5;
  localparam int unsigned TW   = 2;

  // Each record keeps only the fields later stages still consult: M no longer
  // needs rs, and W's Tnew is always 0 so only its destination matters.
  typedef struct packed {
    logic [RegW-1:0] rs;
    logic [RegW-1:0] rt;
    logic [RegW-1:0] a3;
    logic [TW-1:0]   tnew;
  } e_rec_t;

  typedef struct packed {
    logic [RegW-1:0] rt;
    logic [RegW-1:0] a3;
    logic [TW-1:0]   tnew;
  } m_rec_t;

  e_rec_t          e_q, e_d;
  m_rec_t          m_q, m_d;
  logic [RegW-1:0] w_a3_q, w_a3_d;

  // A producer matches a source only for a nonzero destination.
  function automatic logic hit(input logic [RegW-1:0] a3, input logic [RegW-1:0] src);
    return (a3 != '0) && (a3 == src);
  endfunction

  // Two-level priority select: nearer stage encodes 2, farther stage 1.
  function automatic logic [1:0] sel2(input logic near, input logic far);
    if (near)     return 2'd2;
    else if (far) return 2'd1;
    else          return 2'd0;
  endfunction

  // Stall: a producer in E or M whose result arrives later than D needs it.
  always_comb begin
    stall_o = 1'b0;
    if (hit(e_q.a3, d_rs_i) && (d_tuse_rs_i < e_q.tnew)) stall_o = 1'b1;
    if (hit(m_q.a3, d_rs_i) && (d_tuse_rs_i < m_q.tnew)) stall_o = 1'b1;
    if (hit(e_q.a3, d_rt_i) && (d_tuse_rt_i < e_q.tnew)) stall_o = 1'b1;
    if (hit(m_q.a3, d_rt_i) && (d_tuse_rt_i < m_q.tnew)) stall_o = 1'b1;
  end

  // Forward selects: only a ready (Tnew 0) matching stage may drive the bypass.
  always_comb begin
    fwd_d_rs_o = sel2(hit(e_q.a3, d_rs_i) && (e_q.tnew == '0),
                      hit(m_q.a3, d_rs_i) && (m_q.tnew == '0));
    fwd_d_rt_o = sel2(hit(e_q.a3, d_rt_i) && (e_q.tnew == '0),
                      hit(m_q.a3, d_rt_i) && (m_q.tnew == '0));
    fwd_e_rs_o = sel2(hit(m_q.a3, e_q.rs) && (m_q.tnew == '0),
                      hit(w_a3_q, e_q.rs));
    fwd_e_rt_o = sel2(hit(m_q.a3, e_q.rt) && (m_q.tnew == '0),
                      hit(w_a3_q, e_q.rt));
    fwd_m_rt_o = hit(w_a3_q, m_q.rt);
  end

  // Record advance: D into E (or a bubble), E into M with saturating Tnew, M into W.
  always_comb begin
    e_d = '0;
    if (!stall_o && d_valid_i) begin
      e_d.rs   = d_rs_i;
      e_d.rt   = d_rt_i;
      e_d.a3   = d_a3_i;
      e_d.tnew = d_tnew_i;
    end
    m_d.rt   = e_q.rt;
    m_d.a3   = e_q.a3;
    m_d.tnew = (e_q.tnew == '0) ? '0 : (e_q.tnew - TW'(1));
    w_a3_d   = m_q.a3;
  end

  // Record registers; reset empties the shadow pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q    <= '0;
      m_q    <= '0;
      w_a3_q <= '0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      w_a3_q <= w_a3_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios with literal
// expectations plus randomized traffic against an in-bench reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       stall;
  logic [1:0] fd_rs, fd_rt, fe_rs, fe_rt;
  logic       fm_rt;

  int total = 0;
  int bad   = 0;

  hazard_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_valid_i  (d_valid),
    .d_rs_i     (d_rs),
    .d_rt_i     (d_rt),
    .d_tuse_rs_i(d_tuse_rs),
    .d_tuse_rt_i(d_tuse_rt),
    .d_a3_i     (d_a3),
    .d_tnew_i   (d_tnew),
    .stall_o    (stall),
    .fwd_d_rs_o (fd_rs),
    .fwd_d_rt_o (fd_rt),
    .fwd_e_rs_o (fe_rs),
    .fwd_e_rt_o (fe_rt),
    .fwd_m_rt_o (fm_rt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each instruction keeps the Tnew it had on entering E; its remaining latency
  // at stage k (0=E, 1=M, 2=W) is simply max(tnew - k, 0).
  typedef struct {
    int rs;
    int rt;
    int a3;
    int tn;
  } rec_t;

  rec_t pipe [3];
  rec_t nxt  [3];

  function automatic int remain(rec_t r, int k);
    return (r.tn > k) ? (r.tn - k) : 0;
  endfunction

  function automatic bit writes(rec_t r, int s);
    return (r.a3 != 0) && (r.a3 == s);
  endfunction

  // Nearest ready producer among E,M for a D source: E -> 2, M -> 1.
  function automatic int d_sel(int s);
    for (int k = 0; k < 2; k++)
      if (writes(pipe[k], s) && remain(pipe[k], k) == 0) return 2 - k;
    return 0;
  endfunction

  // Nearest ready producer among M,W for an E source: M -> 2, W -> 1.
  function automatic int e_sel(int s);
    for (int k = 1; k < 3; k++)
      if (writes(pipe[k], s) && remain(pipe[k], k) == 0) return 3 - k;
    return 0;
  endfunction

  always @(negedge clk) begin : model_cmp
    int   es;
    rec_t din;
    es = 0;
    for (int k = 0; k < 2; k++) begin
      if (writes(pipe[k], int'(d_rs)) && int'(d_tuse_rs) < remain(pipe[k], k)) es = 1;
      if (writes(pipe[k], int'(d_rt)) && int'(d_tuse_rt) < remain(pipe[k], k)) es = 1;
    end
    chk("m_stall", 32'(stall), 32'(es));
    if (es == 0) begin
      chk("m_fwd_d_rs", 32'(fd_rs), 32'(d_sel(int'(d_rs))));
      chk("m_fwd_d_rt", 32'(fd_rt), 32'(d_sel(int'(d_rt))));
    end
    chk("m_fwd_e_rs", 32'(fe_rs), 32'(e_sel(pipe[0].rs)));
    chk("m_fwd_e_rt", 32'(fe_rt), 32'(e_sel(pipe[0].rt)));
    chk("m_fwd_m_rt", 32'(fm_rt), 32'(writes(pipe[2], pipe[1].rt) ? 1 : 0));
    if (d_valid && es == 0)
      din = '{rs: int'(d_rs), rt: int'(d_rt), a3: int'(d_a3), tn: int'(d_tnew)};
    else
      din = '{rs: 0, rt: 0, a3: 0, tn: 0};
    nxt[0] = din;
    nxt[1] = pipe[0];
    nxt[2] = pipe[1];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) pipe[k] <= '{rs: 0, rt: 0, a3: 0, tn: 0};
    end else begin
      for (int k = 0; k < 3; k++) pipe[k] <= nxt[k];
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input int rs, input int rt, input int urs,
                       input int urt, input int a3, input int tn);
    d_valid   = v;
    d_rs      = 5'(rs);
    d_rt      = 5'(rt);
    d_tuse_rs = 2'(urs);
    d_tuse_rt = 2'(urt);
    d_a3      = 5'(a3);
    d_tnew    = 2'(tn);
  endtask

  // Present one D instruction for a cycle; return at the sampling edge.
  task automatic cyc(input bit v, input int rs, input int rt, input int urs,
                     input int urt, input int a3, input int tn);
    @(posedge clk);
    #1;
    drive(v, rs, rt, urs, urt, a3, tn);
    @(negedge clk);
  endtask

  task automatic bub();
    cyc(1'b0, 0, 0, 3, 3, 0, 0);
  endtask

  task automatic flush();
    repeat (3) bub();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall), 0);
    chk({tag, "_fdrs"},  32'(fd_rs), 0);
    chk({tag, "_fdrt"},  32'(fd_rt), 0);
    chk({tag, "_fers"},  32'(fe_rs), 0);
    chk({tag, "_fert"},  32'(fe_rt), 0);
    chk({tag, "_fmrt"},  32'(fm_rt), 0);
  endtask

  initial begin
    drive(1'b0, 0, 0, 3, 3, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    flush();

    // Load-use: lw $8 then addu reading $8 at Tuse 1.
    cyc(1'b1, 0, 0, 3, 3, 8, 2);
    cyc(1'b1, 8, 0, 1, 3, 9, 1);
    chk("lu_stall1", 32'(stall), 1);
    cyc(1'b1, 8, 0, 1, 3, 9, 1);
    chk("lu_stall2", 32'(stall), 0);
    bub();
    chk("lu_fwd_e_rs", 32'(fe_rs), 1);
    flush();

    // Branch after ALU: one stall, then M forwards to D.
    cyc(1'b1, 0, 0, 3, 3, 9, 1);
    cyc(1'b1, 9, 0, 0, 3, 0, 0);
    chk("br_alu_stall1", 32'(stall), 1);
    cyc(1'b1, 9, 0, 0, 3, 0, 0);
    chk("br_alu_stall2", 32'(stall), 0);
    chk("br_alu_fdrs", 32'(fd_rs), 1);
    flush();

    // Load then branch on it: two stalls, then value comes from the RF bypass.
    cyc(1'b1, 0, 0, 3, 3, 10, 2);
    cyc(1'b1, 10, 0, 0, 3, 0, 0);
    chk("br_lw_stall1", 32'(stall), 1);
    cyc(1'b1, 10, 0, 0, 3, 0, 0);
    chk("br_lw_stall2", 32'(stall), 1);
    cyc(1'b1, 10, 0, 0, 3, 0, 0);
    chk("br_lw_stall3", 32'(stall), 0);
    chk("br_lw_fdrs", 32'(fd_rs), 0);
    flush();

    // Link forwarding: jal $31 then jr $31.
    cyc(1'b1, 0, 0, 3, 3, 31, 0);
    cyc(1'b1, 31, 0, 0, 3, 0, 0);
    chk("jal_stall", 32'(stall), 0);
    chk("jal_fdrs", 32'(fd_rs), 2);
    flush();

    // Store data: lw $8 then sw rt=8 at Tuse 2.
    cyc(1'b1, 0, 0, 3, 3, 8, 2);
    cyc(1'b1, 29, 8, 1, 2, 0, 0);
    chk("sw_stall", 32'(stall), 0);
    bub();
    chk("sw_fert", 32'(fe_rt), 0);
    bub();
    chk("sw_fmrt", 32'(fm_rt), 1);
    flush();

    // Register 0 is never a dependency.
    cyc(1'b1, 0, 0, 3, 3, 0, 0);
    cyc(1'b1, 0, 0, 0, 0, 0, 0);
    chk("zero_stall", 32'(stall), 0);
    chk("zero_fdrs", 32'(fd_rs), 0);
    chk("zero_fdrt", 32'(fd_rt), 0);
    bub();
    chk("zero_fers", 32'(fe_rs), 0);
    flush();

    // Back-to-back writers of $5: E wins over M.
    cyc(1'b1, 0, 0, 3, 3, 5, 0);
    cyc(1'b1, 0, 0, 3, 3, 5, 0);
    cyc(1'b1, 5, 0, 0, 3, 0, 0);
    chk("prio_stall", 32'(stall), 0);
    chk("prio_fdrs", 32'(fd_rs), 2);
    flush();

    // Reset asserted in the middle of a load-use stall.
    cyc(1'b1, 0, 0, 3, 3, 8, 2);
    cyc(1'b1, 8, 8, 1, 1, 9, 1);
    chk("rs_pre_stall", 32'(stall), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rs_async");
    @(posedge clk);
    #3;
    drive(1'b0, 0, 0, 3, 3, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rs_rel_stall", 32'(stall), 0);
    bub();
    chk("rs_rel_stall2", 32'(stall), 0);
    flush();

    // Randomized traffic on a small register set, with occasional reset pulses.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 149) != 0);
      drive($urandom_range(0, 99) < 85,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
